// File: rtl/hex_scroll_ctrl.sv
// Scrolling "HELLO" sequencer for four active-low 7-segment digits.
// Run/pause, direction and a blink burst on message wrap come from the slide switches.
module hex_scroll_ctrl #(
  parameter int TICK_DIV    = 25000000,
  parameter int MSG_LEN     = 8,
  parameter int BLINK_COUNT = 3
) (
  input  logic       CLOCK_50,
  input  logic [3:0] SW,
  output logic [7:0] HEX3,
  output logic [7:0] HEX2,
  output logic [7:0] HEX1,
  output logic [7:0] HEX0,
  output logic [4:0] LEDR
);

  localparam int NUM_DIG = 4;
  localparam int POS_W   = $clog2(MSG_LEN);
  localparam int PRE_W   = $clog2(TICK_DIV);
  localparam int CNT_W   = $clog2(2 * BLINK_COUNT + 1);

  localparam logic [PRE_W-1:0] TICK_MAX  = PRE_W'(TICK_DIV - 1);
  localparam logic [POS_W-1:0] POS_MAX   = POS_W'(MSG_LEN - 1);
  localparam logic [CNT_W-1:0] BLINK_END = CNT_W'(2 * BLINK_COUNT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCROLL = 2'd1,
    PAUSE  = 2'd2,
    BLINK  = 2'd3
  } state_e;

  function automatic logic [7:0] msg_char(input logic [POS_W-1:0] idx);
    case (idx)
      3'd0:    msg_char = 8'h89;
      3'd1:    msg_char = 8'h86;
      3'd2:    msg_char = 8'hC7;
      3'd3:    msg_char = 8'hC7;
      3'd4:    msg_char = 8'hC0;
      default: msg_char = 8'hFF;
    endcase
  endfunction

  logic                 rst, run, dir_right, blink_en;
  state_e               state_q, state_d;
  logic [POS_W-1:0]     pos_q, pos_d, pos_step;
  logic [PRE_W-1:0]     presc_q, presc_d;
  logic [CNT_W-1:0]     blink_cnt_q, blink_cnt_d;
  logic                 phase_q, phase_d;
  logic                 tick, wrap, blank;
  logic [NUM_DIG-1:0][7:0] hex_q, hex_d;
  logic [4:0]           ledr_q, ledr_d;

  assign rst       = SW[0];
  assign run       = SW[1];
  assign dir_right = SW[2];
  assign blink_en  = SW[3];

  assign tick     = (presc_q == TICK_MAX);
  assign presc_d  = tick ? '0 : presc_q + 1'b1;
  assign pos_step = dir_right ? pos_q - 1'b1 : pos_q + 1'b1;
  assign wrap     = dir_right ? (pos_q == '0) : (pos_q == POS_MAX);

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    case (state_q)
      IDLE: begin
        if (run) begin
          state_d = SCROLL;
          pos_d   = '0;
        end
      end
      SCROLL: begin
        // Dropping run wins over a coincident tick so pos stays put.
        if (!run) begin
          state_d = PAUSE;
        end else if (tick) begin
          pos_d = pos_step;
          if (wrap && blink_en) begin
            state_d     = BLINK;
            blink_cnt_d = '0;
            phase_d     = 1'b0;
          end
        end
      end
      PAUSE: begin
        if (run) state_d = SCROLL;
      end
      BLINK: begin
        if (!run) begin
          state_d     = PAUSE;
          blink_cnt_d = '0;
          phase_d     = 1'b0;
        end else if (tick) begin
          blink_cnt_d = blink_cnt_q + 1'b1;
          phase_d     = ~phase_q;
          if (blink_cnt_d == BLINK_END) begin
            state_d     = SCROLL;
            blink_cnt_d = '0;
            phase_d     = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Display is built from the current-cycle state and registered below.
  assign blank  = (state_q == IDLE) || ((state_q == BLINK) && phase_q);
  assign ledr_d = {pos_q, state_q};

  for (genvar k = 0; k < NUM_DIG; k++) begin : g_dig
    assign hex_d[NUM_DIG-1-k] = blank ? 8'hFF : msg_char(pos_q + POS_W'(k));
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state_q     <= IDLE;
      pos_q       <= '0;
      presc_q     <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      hex_q       <= {NUM_DIG{8'hFF}};
      ledr_q      <= '0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      presc_q     <= presc_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      hex_q       <= hex_d;
      ledr_q      <= ledr_d;
    end
  end

  assign HEX3 = hex_q[3];
  assign HEX2 = hex_q[2];
  assign HEX1 = hex_q[1];
  assign HEX0 = hex_q[0];
  assign LEDR = ledr_q;

endmodule

// File: doc/hex_scroll_ctrl.md
Name: hex_scroll_ctrl

Overview:
Display sequencer for the four 7-segment digits HEX3..HEX0. It scrolls a fixed 8-character message ("HELLO" plus 3 blanks) across the digits at a prescaled tick rate. Slide switches select run/pause, direction, and an optional blink burst each time the message wraps. It sits between the board clock/switches and the active-low HEX outputs, and owns the display timing.

Parameters:
TICK_DIV, 25000000, CLOCK_50 cycles per scroll tick (0.5 s); minimum 2.
MSG_LEN, 8, message length in characters; must be 8 for the fixed message table.
BLINK_COUNT, 3, number of off/on blink pairs after a wrap.

Ports:
CLOCK_50  input  1  system clock, 50 MHz, all logic on the rising edge.
SW  input  4  SW[0] = reset (synchronous, active-high); SW[1] = run; SW[2] = direction (0 = left, 1 = right); SW[3] = blink-on-wrap enable.
HEX3  output  8  leftmost digit, active-low segments, bit7 = dp (always 1 = off).
HEX2  output  8  digit 2, same encoding as HEX3.
HEX1  output  8  digit 1, same encoding as HEX3.
HEX0  output  8  rightmost digit, same encoding as HEX3.
LEDR  output  5  status: [1:0] = state code, [4:2] = pos.

Behaviour:
- Clocking and reset:
  - Single clock CLOCK_50.
  - SW[0] is sampled on the rising edge; reset is synchronous, active-high, and overrides all other inputs.
- Reset values:
  - state = IDLE, pos = 0, prescaler = 0, blink_cnt = 0, phase = 0.
  - HEX3..HEX0 = 8'hFF, LEDR = 0.
- Message table, index 0..7: H=8'h89, E=8'h86, L=8'hC7, L=8'hC7, O=8'hC0, blank=8'hFF, blank=8'hFF, blank=8'hFF.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - tick = 1 for exactly one cycle when count == TICK_DIV-1.
  - Free-running in every state except during reset.
- Display mapping: HEX(3-k) = msg[(pos+k) mod 8] for k = 0..3, so HEX3 shows msg[pos].
- Output timing: HEX and LEDR are registered and reflect the state, pos and phase of the previous cycle (1-cycle latency).
- States (LEDR[1:0] code):
  - IDLE (0):
    - HEX all 8'hFF.
    - SW[1]=1 -> SCROLL on the next cycle, with pos = 0.
  - SCROLL (1):
    - On tick: pos = pos+1 mod 8 if SW[2]=0, or pos-1 mod 8 if SW[2]=1.
    - A wrap is a left step 7->0 or a right step 0->7. If SW[3]=1 on a wrap tick -> BLINK with blink_cnt = 0 and phase = 0.
    - SW[1]=0 -> PAUSE. This has priority over a tick in the same cycle; pos does not advance.
  - PAUSE (2):
    - pos frozen; message displayed.
    - SW[1]=1 -> SCROLL. The next advance occurs on the next natural tick; the prescaler is not reset.
  - BLINK (3):
    - pos frozen. phase=1 shows all 8'hFF; phase=0 shows the message.
    - Each tick toggles phase and increments blink_cnt.
    - When blink_cnt reaches 2*BLINK_COUNT, go to SCROLL with phase = 0. The tick that completes the blink does not advance pos.
    - SW[1]=0 -> PAUSE with blink_cnt = 0 and phase = 0.
- Mid-operation input changes:
  - SW[2] changed mid-scroll takes effect on the next tick.
  - SW[3] is only sampled on wrap ticks.
  - Reset in any state returns to IDLE on the next edge.
- IDLE is left only via SW[1]; it is re-entered only via reset.

Test Plan:
1. Reset then run left: TICK_DIV=4, SW=4'b0001 for 2 cycles, then SW=4'b0010 -> HEX all FF during reset. One cycle after leaving IDLE: HEX3..0 = 89,86,C7,C7. After the first tick: 86,C7,C7,C0.
2. Left wrap, no blink: run 8 ticks with SW[3]=0 -> pos goes 0..7 then back to 0. At pos=7 the display is FF,89,86,C7. No BLINK code on LEDR[1:0].
3. Blink on wrap: SW[3]=1, step left from pos 7 -> LEDR[1:0]=3. HEX alternates FF×4 / message at pos 0 on each tick for 6 ticks, then LEDR[1:0]=1 with pos still 0.
4. Right direction: from pos=0, SW[2]=1, one tick -> pos=7, LEDR[4:2]=7, HEX3..0 = FF,89,86,C7. With SW[3]=1 this step enters BLINK.
5. Pause and resume: drop SW[1] in the same cycle as a tick -> LEDR[1:0]=2 and pos unchanged for 10 ticks. Raise SW[1] -> pos advances on the next tick only.
6. Reset mid-BLINK: assert SW[0] during phase=1 -> next edge gives HEX all FF, LEDR=0, prescaler=0. Releasing reset with SW[1]=1 restarts at pos 0.
